// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port data memory between the pipeline MEM stage
//            (cpu, requester 0) and a loader/DMA port (dma, requester 1).
//            Grants are combinational, with round-robin on ties and a bounded
//            DMA lock burst. Byte enables come from the store option, and
//            misaligned stores are suppressed and flagged. Read data is
//            registered and returned one cycle after the grant.
// Ports    : clock, reset_n           - clock / async active-low reset
//            cpu_* / dma_*            - request side (req, we, sop, addr, wdata)
//            dma_lock                 - DMA asks for back-to-back grants
//            *_gnt                    - combinational grant
//            *_rvalid/*_rdata/*_err   - one-cycle-later response
//            mem_addr/din/be/we       - memory request, zero when idle
//            mem_dout                 - combinational memory read word
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_sop,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [1:0]  dma_sop,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        cpu_gnt,
  output logic        dma_gnt,
  output logic        cpu_rvalid,
  output logic        dma_rvalid,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dma_rdata,
  output logic        cpu_err,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  localparam logic [0:0] LAST_CPU    = 1'b0;
  localparam logic [0:0] LAST_DMA    = 1'b1;
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  logic [0:0]  last_grant;
  logic [3:0]  burst_cnt;
  logic        cpu_v_q;
  logic        dma_v_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        granted;
  logic        sel_we;
  logic [1:0]  sel_sop;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  sop_be;

  // Grant selection. Gated by reset_n so every output reads 0 while the
  // block is held in reset, even if requesters keep their lines high.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (reset_n) begin
      if (cpu_req && dma_req) begin
        if (dma_lock && (last_grant == LAST_DMA) && (burst_cnt < BURST_LIMIT)) begin
          dma_gnt = 1'b1;
        end else if (last_grant == LAST_DMA) begin
          cpu_gnt = 1'b1;
        end else begin
          dma_gnt = 1'b1;
        end
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  assign granted = cpu_gnt | dma_gnt;

  // Request mux; all fields fall to zero when nobody is granted.
  always_comb begin
    sel_we    = 1'b0;
    sel_sop   = 2'b00;
    sel_addr  = 32'h0;
    sel_wdata = 32'h0;
    if (cpu_gnt) begin
      sel_we    = cpu_we;
      sel_sop   = cpu_sop;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      sel_we    = dma_we;
      sel_sop   = dma_sop;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  always_comb begin
    case (sel_sop)
      2'b01:   sop_be = 4'b0001;
      2'b10:   sop_be = 4'b0011;
      default: sop_be = 4'b1111;  // word, and the reserved code reads a full word
    endcase
  end

  // The reserved store option behaves as a load: no write, no error.
  assign is_store   = sel_we & (sel_sop != 2'b11);
  assign misaligned = is_store &
                      (((sel_sop == 2'b10) & sel_addr[0]) |
                       ((sel_sop == 2'b00) & (sel_addr[1:0] != 2'b00)));

  assign mem_addr = sel_addr;
  assign mem_din  = sel_wdata;
  assign mem_be   = granted ? sop_be : 4'b0000;
  assign mem_we   = granted & is_store & ~misaligned;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= LAST_DMA;
      burst_cnt  <= 4'd0;
      cpu_v_q    <= 1'b0;
      dma_v_q    <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      if (cpu_gnt) begin
        last_grant <= LAST_CPU;
      end else if (dma_gnt) begin
        last_grant <= LAST_DMA;
      end

      if (dma_gnt && dma_lock) begin
        if (burst_cnt < BURST_LIMIT) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else begin
        burst_cnt <= 4'd0;
      end

      cpu_v_q <= cpu_gnt;
      dma_v_q <= dma_gnt;
      // Read-before-write: a store returns the word as it was before commit.
      rdata_q <= (granted && !misaligned) ? mem_dout : 32'h0;
      err_q   <= misaligned;
    end
  end

  assign cpu_rvalid = cpu_v_q;
  assign dma_rvalid = dma_v_q;
  assign cpu_rdata  = cpu_v_q ? rdata_q : 32'h0;
  assign dma_rdata  = dma_v_q ? rdata_q : 32'h0;
  assign cpu_err    = cpu_v_q & err_q;
  assign dma_err    = dma_v_q & err_q;

endmodule
`default_nettype wire
